coin_acceptor: RTL
==================

Name: coin_acceptor

Overview:
- Front-end stage directly upstream of the vending-machine FSM.
- Conditions two raw, bouncing, asynchronous coin-sensor lines (0.5 and 1.0 units) into clean single-cycle coin codes on coin[1:0] (01 = 0.5, 10 = 1.0, 00 = none), which the FSM consumes.
- Buffers one coin per denomination while the downstream FSM is in a vend state (hold asserted), so coins are not lost.
- Flags a reject when a coin cannot be buffered.

Parameters:
- DEB_CYCLES, 4: consecutive synchronized samples a level must hold before it is accepted; legal range 2..255.
- CNT_W, $clog2(DEB_CYCLES+1): width of the debounce counter (derived, not overridden).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- coin05_raw  in  1  raw 0.5-unit sensor; asynchronous, may bounce
- coin10_raw  in  1  raw 1.0-unit sensor; asynchronous, may bounce
- hold  in  1  downstream busy (vend state); suppresses coin output
- coin  out  2  registered coin code to FSM; one-cycle pulses only
- reject  out  1  registered one-cycle pulse; coin returned, buffer full
- stat_05  out  8  (STATS only) accepted 0.5 count
- stat_10  out  8  (STATS only) accepted 1.0 count
- stat_rej  out  8  (STATS only) reject count

Behaviour:
- Reset (async, rstn low): coin=00, reject=0, both synchronizers 0, debounced levels 0, counters 0, pending flags 0. Release is synchronous to the next clk edge.
- Synchronizer: 2-flop per channel; s05/s10 are the second-flop outputs.
- Debounce (per channel, independent):
  - state is deb_level plus a counter cnt.
  - If s == deb_level: cnt cleared.
  - Else if cnt == DEB_CYCLES-1: deb_level flips, cnt cleared.
  - Else: cnt increments.
  - A level must therefore differ for DEB_CYCLES consecutive samples. Any glitch back to deb_level restarts the count.
- Accept event: deb_level flips 0->1 (rising only). The falling flip generates no event but is still debounced.
- Pending flags pend05/pend10 are a 1-entry buffer per channel. On each edge, per channel:
  - Event and flag clear (or flag being emitted this edge): flag set.
  - Event and flag set, not being emitted: flag unchanged; reject pulses next cycle.
  - No event, flag being emitted: flag cleared.
- Output arbitration, registered, evaluated each edge:
  - hold=1: coin<=00, flags retained.
  - hold=0, pend05=1: coin<=01, pend05 consumed.
  - hold=0, pend05=0, pend10=1: coin<=10, pend10 consumed.
  - Otherwise coin<=00.
  - 0.5 has fixed priority; only one coin per cycle; coin==11 is never driven.
- Events vs. output:
  - A new event sets its flag at edge N. Output follows at edge N+1 at the earliest.
  - Events are never emitted combinationally.
- Latency: raw stable high sampled from edge 0 gives deb_level=1 and flag set at edge DEB_CYCLES+1, and coin pulse for one cycle after edge DEB_CYCLES+2 (hold=0, no competing flag).
- Simultaneous 0.5 and 1.0 acceptance: coin=01 on the first cycle, 10 on the next.
- If both reject conditions coincide: one reject pulse (OR). With STATS, stat_rej increments by 1.
- Reset mid-operation clears pending coins silently; no reject is issued.

Optional Feature:
- Macro COIN_ACC_STATS_EN.
- Defined: stat_05/stat_10/stat_rej ports and 8-bit counters exist.
  - Reset value 0.
  - stat_05/stat_10 increment on the edge coin is driven to 01/10 (emitted, not accepted).
  - stat_rej increments with each reject pulse.
  - All saturate at 255.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan (DEB_CYCLES=4):
- Reset then coin05_raw held high from edge 0, hold=0 -> coin=01 for exactly the one cycle after edge 6, then 00; reject stays 0.
- coin10_raw pulses high 3 cycles, low 1, high 3 (bounce) -> no coin; then held high 4+ cycles -> a single coin=10 pulse.
- Both raw lines rise on the same cycle -> coin=01 after edge 6, coin=10 after edge 7.
- hold=1 while one 0.5 coin is accepted, then a second 0.5 is accepted before hold drops -> reject=1 for one cycle; on hold=0 exactly one coin=01 is emitted; with COIN_ACC_STATS_EN, stat_rej=1 and stat_05=1.
- pend10 set with hold=1, then rstn pulsed low -> coin=00 and reject=0 after release; no 10 is emitted later.
- With COIN_ACC_STATS_EN, 260 clean 0.5 coins -> stat_05 saturates at 255, coin pulses keep arriving.

Source files
------------

// File: rtl/coin_acceptor.sv
`timescale 1ns/1ps
// Coin-sensor front end: 2-flop synchronizers, debounce, 1-deep per-denomination buffer, reject.
// Optional statistics counters when COIN_ACC_STATS_EN is defined.
module coin_acceptor #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       coin05_raw,
    input  logic       coin10_raw,
    input  logic       hold,
    output logic [1:0] coin,
    output logic       reject
`ifdef COIN_ACC_STATS_EN
    ,
    output logic [7:0] stat_05,
    output logic [7:0] stat_10,
    output logic [7:0] stat_rej
`endif
);

    localparam int                CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0] raw;
    logic [1:0] accept;
    logic [1:0] emit;
    logic [1:0] overflow;
    logic [1:0] pend_reg;
    logic [1:0] pend_next;

    assign raw = {coin10_raw, coin05_raw};

    // Bit 0 is the 0.5 channel and wins arbitration, so emit is one-hot by construction.
    assign emit[0] = ~hold & pend_reg[0];
    assign emit[1] = ~hold & ~pend_reg[0] & pend_reg[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic             sync1_reg;
            logic             sync2_reg;
            logic             level_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             differ;
            logic             expire;

            assign differ = sync2_reg != level_reg;
            assign expire = differ && (cnt_reg == CNT_LAST);

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                    if (!differ) begin
                        cnt_reg <= '0;
                    end else if (expire) begin
                        level_reg <= ~level_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end

            // Only the rising flip of the debounced level is a coin.
            assign accept[gi] = expire & sync2_reg;

            // A slot being emitted this edge can take the new coin; an occupied one cannot.
            assign pend_next[gi] = accept[gi] | (pend_reg[gi] & ~emit[gi]);
            assign overflow[gi]  = accept[gi] & pend_reg[gi] & ~emit[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_reg <= 2'b00;
            coin     <= 2'b00;
            reject   <= 1'b0;
        end else begin
            pend_reg <= pend_next;
            coin     <= emit;
            reject   <= |overflow;
        end
    end

`ifdef COIN_ACC_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_05  <= 8'd0;
            stat_10  <= 8'd0;
            stat_rej <= 8'd0;
        end else begin
            if (emit[0] && stat_05 != 8'hFF)
                stat_05 <= stat_05 + 8'd1;
            if (emit[1] && stat_10 != 8'hFF)
                stat_10 <= stat_10 + 8'd1;
            if ((|overflow) && stat_rej != 8'hFF)
                stat_rej <= stat_rej + 8'd1;
        end
    end
`endif

endmodule
